prim_cmd_sequencer: RTL and testbench

- Buffers 16-bit primitive-renderer commands written by the host register interface in a FIFO.
- Issues the buffered commands to the primitive renderer one at a time.
- Holds back all further commands while a line is drawing, so coordinate and colour registers never change under an active draw.
- Sits between the host register decode and the renderer's cmd_i/cmd_valid_i/busy_o interface.

---
 rtl/prim_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_prim_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prim_cmd_sequencer
//  Purpose  : FIFO-buffered command sequencer between host register decode
//             and the primitive renderer. Issues one command per cycle and
//             holds issue from a start command (opcode 0xF) until the
//             renderer's busy has risen and fallen again.
//  Options  : PRIM_SEQ_STATS_EN - builds the 16-bit completed-draw counter
//             driving lines_done_o (tied to zero otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module prim_cmd_sequencer #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic [15:0]              host_cmd_i,
    input  logic                     host_cmd_valid_i,
    output logic                     host_cmd_ready_o,
    input  logic                     clear_i,
    output logic [15:0]              cmd_o,
    output logic                     cmd_valid_o,
    input  logic                     rndr_busy_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     timeout_o,
    output logic                     idle_o,
    output logic [15:0]              lines_done_o
);

    localparam int               c_AW        = $clog2(DEPTH);
    localparam int               c_TW        = $clog2(START_TIMEOUT + 1) + 1;
    localparam logic [c_AW:0]    c_FULL      = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]    c_LVL_ONE   = (c_AW + 1)'(1);
    localparam logic [c_TW-1:0]  c_TIMER_ONE = c_TW'(1);
    localparam logic [3:0]       c_OP_START  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_START_WAIT = 2'd2,
        S_DRAW_WAIT  = 2'd3
    } state_t;

    logic [15:0]      r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_TW-1:0]  r_timer;
    logic [c_TW-1:0]  w_timer_nxt;
    logic [15:0]      r_cmd;
    logic             r_cmd_valid;
    logic             r_ready;
    logic             r_overflow;
    logic             r_timeout;
    logic             r_idle;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_can_issue;
    logic             w_set_timeout;
    logic             w_timer_hit;
    logic [c_AW:0]    w_level_nxt;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_FULL);
    assign w_push      = host_cmd_valid_i && !w_full && !clear_i;
    assign w_timer_hit = (int'(r_timer) + 1) >= START_TIMEOUT;

    // Issue gating and next-state; leaving DRAW_WAIT may pop in the same
    // cycle so the next command follows busy falling by exactly one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_can_issue   = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE:      w_can_issue = 1'b1;
            S_ISSUE:     w_can_issue = (r_cmd[15:12] != c_OP_START);
            S_DRAW_WAIT: w_can_issue = !rndr_busy_i;
            default:     w_can_issue = 1'b0;
        endcase
        w_pop = w_can_issue && !w_empty && !clear_i;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_pop) begin
                    w_state_nxt = S_ISSUE;
                end else if (r_cmd[15:12] == c_OP_START) begin
                    w_state_nxt = S_START_WAIT;
                    w_timer_nxt = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START_WAIT: begin
                if (rndr_busy_i) begin
                    w_state_nxt = S_DRAW_WAIT;
                end else if (w_timer_hit) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + c_TIMER_ONE;
                end
            end
            S_DRAW_WAIT: begin
                if (!rndr_busy_i) w_state_nxt = w_pop ? S_ISSUE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A flush cannot abort a draw that is still running.
        if (clear_i && !(r_state == S_DRAW_WAIT && rndr_busy_i)) begin
            w_state_nxt   = S_IDLE;
            w_set_timeout = 1'b0;
        end
    end

    // Occupancy after this cycle's push/pop/flush.
    always_comb begin
        w_level_nxt = r_level;
        if (clear_i) begin
            w_level_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + c_LVL_ONE;
                2'b01:   w_level_nxt = r_level - c_LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // FIFO storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= host_cmd_i;
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_level     <= w_level_nxt;
            r_ready     <= (w_level_nxt != c_FULL);
            r_idle      <= (w_level_nxt == '0) && (w_state_nxt == S_IDLE) && !rndr_busy_i;
            r_cmd_valid <= w_pop;
            if (w_pop) r_cmd <= r_mem[r_rptr];
            if (clear_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            if (clear_i)
                r_overflow <= 1'b0;
            else if (host_cmd_valid_i && w_full)
                r_overflow <= 1'b1;
            if (clear_i)
                r_timeout <= 1'b0;
            else if (w_set_timeout)
                r_timeout <= 1'b1;
        end
    end

    assign cmd_o            = r_cmd;
    assign cmd_valid_o      = r_cmd_valid;
    assign host_cmd_ready_o = r_ready;
    assign fifo_level_o     = r_level;
    assign overflow_o       = r_overflow;
    assign timeout_o        = r_timeout;
    assign idle_o           = r_idle;

`ifdef PRIM_SEQ_STATS_EN
    logic        w_draw_done;
    logic [15:0] r_lines;
    assign w_draw_done = (r_state == S_DRAW_WAIT) && !rndr_busy_i;

    // Completed-draw counter; survives clear_i, wraps at 16 bits.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)
            r_lines <= 16'd0;
        else if (w_draw_done)
            r_lines <= r_lines + 16'd1;
    end
    assign lines_done_o = r_lines;
`else
    assign lines_done_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prim_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prim_cmd_sequencer
//  Purpose  : Self-checking bench for prim_cmd_sequencer with a queue-based
//             reference model, a simple renderer model and directed tests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prim_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int TO    = 4;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [15:0] host_cmd_i = 16'd0;
    logic        host_cmd_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        rndr_busy_i = 1'b0;
    logic        host_cmd_ready_o;
    logic [15:0] cmd_o;
    logic        cmd_valid_o;
    logic [4:0]  fifo_level_o;
    logic        overflow_o;
    logic        timeout_o;
    logic        idle_o;
    logic [15:0] lines_done_o;

    prim_cmd_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset_n_i        (reset_n_i),
        .host_cmd_i       (host_cmd_i),
        .host_cmd_valid_i (host_cmd_valid_i),
        .host_cmd_ready_o (host_cmd_ready_o),
        .clear_i          (clear_i),
        .cmd_o            (cmd_o),
        .cmd_valid_o      (cmd_valid_o),
        .rndr_busy_i      (rndr_busy_i),
        .fifo_level_o     (fifo_level_o),
        .overflow_o       (overflow_o),
        .timeout_o        (timeout_o),
        .idle_o           (idle_o),
        .lines_done_o     (lines_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Renderer: busy rises rnd_dly cycles after a start command, stays rnd_hold cycles.
    int rnd_dly    = 2;
    int rnd_hold   = 20;
    bit rnd_rise   = 1'b1;
    int rnd_cnt    = -1;
    int rnd_hcnt   = 0;
    always @(posedge clk) begin
        #1;
        if (!reset_n_i) begin
            rndr_busy_i = 1'b0;
            rnd_cnt     = -1;
            rnd_hcnt    = 0;
        end else begin
            if (rndr_busy_i) begin
                rnd_hcnt--;
                if (rnd_hcnt <= 0) rndr_busy_i = 1'b0;
            end else if (rnd_cnt > 0) begin
                rnd_cnt--;
                if (rnd_cnt == 0) begin
                    rndr_busy_i = 1'b1;
                    rnd_hcnt    = rnd_hold;
                    rnd_cnt     = -1;
                end
            end
            if (cmd_valid_o && cmd_o[15:12] == 4'hF && rnd_rise) rnd_cnt = rnd_dly;
        end
    end

    // Issue log and busy falling-edge tracker.
    int          log_cyc [$];
    logic [15:0] log_val [$];
    int          fall_cyc  = -1;
    logic        prev_busy = 1'b0;
    always @(negedge clk) begin
        if (cmd_valid_o) begin
            log_cyc.push_back(cyc);
            log_val.push_back(cmd_o);
        end
        if (prev_busy && !rndr_busy_i) fall_cyc = cyc;
        prev_busy = rndr_busy_i;
    end

    // Reference model: a word queue plus "blocked" bookkeeping
    // (start-wait countdown, draw in progress).
    logic [15:0] mq [$];
    bit          m_valid = 1'b0;
    logic [15:0] m_cmd   = 16'd0;
    int          m_sw    = -1;
    bit          m_draw  = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_to    = 1'b0;
    bit          m_idle  = 1'b1;
    int          m_lines = 0;
    bit          mb_can, mb_pop, mb_start, mb_full;

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mq.delete();
            m_valid = 1'b0; m_cmd = 16'd0; m_sw = -1; m_draw = 1'b0;
            m_ovf = 1'b0; m_to = 1'b0; m_idle = 1'b1; m_lines = 0;
        end else begin
            mb_start = m_valid && (m_cmd[15:12] == 4'hF);
            if (m_draw)        mb_can = !rndr_busy_i;
            else if (m_sw >= 0) mb_can = 1'b0;
            else               mb_can = !mb_start;
            mb_full = (mq.size() == DEPTH);
            mb_pop  = mb_can && (mq.size() > 0) && !clear_i;
            if (m_draw) begin
                if (!rndr_busy_i) begin
                    m_draw  = 1'b0;
                    m_lines = (m_lines + 1) % 65536;
                end
            end else if (m_sw >= 0) begin
                if (clear_i) m_sw = -1;
                else if (rndr_busy_i) begin m_sw = -1; m_draw = 1'b1; end
                else if (m_sw + 1 >= TO) begin m_sw = -1; m_to = 1'b1; end
                else m_sw++;
            end else if (mb_start && !clear_i) begin
                m_sw = 0;
            end
            if (clear_i) begin
                m_ovf = 1'b0;
                m_to  = 1'b0;
                mq.delete();
            end else begin
                if (mb_pop) m_cmd = mq.pop_front();
                if (host_cmd_valid_i) begin
                    if (mb_full) m_ovf = 1'b1;
                    else         mq.push_back(host_cmd_i);
                end
            end
            m_valid = mb_pop;
            m_idle  = (mq.size() == 0) && !m_valid && (m_sw < 0) && !m_draw && !rndr_busy_i;
        end
    end

    function automatic logic [15:0] exp_lines(input int n);
`ifdef PRIM_SEQ_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmd_valid", cmd_valid_o, m_valid);
        chk("cmd", cmd_o, m_cmd);
        chk("level", fifo_level_o, mq.size());
        chk("ready", host_cmd_ready_o, mq.size() != DEPTH);
        chk("overflow", overflow_o, m_ovf);
        chk("timeout", timeout_o, m_to);
        chk("idle", idle_o, m_idle);
        chk("lines", lines_done_o, exp_lines(m_lines));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [15:0] w);
        host_cmd_i       = w;
        host_cmd_valid_i = 1'b1;
        tick();
        host_cmd_valid_i = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int lim, input string nm);
        int k = 0;
        while (rndr_busy_i !== val && k < lim) begin
            tick();
            k++;
        end
        chk(nm, rndr_busy_i, val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] t1w [6] = '{16'h0010, 16'h1020, 16'h2030, 16'h3040, 16'h4005, 16'hF000};
    int P;
    int base;

    initial begin
        ticks(3);
        reset_n_i = 1'b1;
        tick();
        chk("rst_ready", host_cmd_ready_o, 1);
        chk("rst_idle", idle_o, 1);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_valid", cmd_valid_o, 0);

        // Six back-to-back commands ending in a start.
        rnd_rise = 1'b1; rnd_dly = 2; rnd_hold = 20;
        base = log_cyc.size();
        P = cyc;
        for (int i = 0; i < 6; i++) begin
            host_cmd_i = t1w[i];
            host_cmd_valid_i = 1'b1;
            tick();
        end
        host_cmd_valid_i = 1'b0;
        ticks(40);
        chk("t1_npulse", log_cyc.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            chk("t1_val", log_val[base + i], t1w[i]);
            chk("t1_cyc", log_cyc[base + i], P + 2 + i);
        end
        chk("t1_lines", lines_done_o, exp_lines(1));
        chk("t1_idle", idle_o, 1);

        // Command queued behind a start waits for busy to fall.
        rnd_hold = 50;
        base = log_cyc.size();
        P = cyc;
        push(16'hF000);
        push(16'h0005);
        ticks(70);
        chk("t2_npulse", log_cyc.size() - base, 2);
        chk("t2_val", log_val[base + 1], 16'h0005);
        chk("t2_cyc", log_cyc[base + 1], P + 55);
        chk("t2_after_fall", log_cyc[base + 1], fall_cyc + 1);

        // Overflow while the draw blocks draining.
        rnd_hold = 200;
        push(16'hF000);
        wait_busy(1'b1, 20, "t3_busy_up");
        base = log_cyc.size();
        for (int i = 0; i <= DEPTH; i++) begin
            host_cmd_i = 16'h1000 + 16'(i);
            host_cmd_valid_i = 1'b1;
            tick();
        end
        host_cmd_valid_i = 1'b0;
        chk("t3_level", fifo_level_o, 16);
        chk("t3_ready", host_cmd_ready_o, 0);
        chk("t3_ovf", overflow_o, 1);
        wait_busy(1'b0, 250, "t3_busy_down");
        ticks(25);
        chk("t3_ndrain", log_cyc.size() - base, 16);
        chk("t3_last", log_val[log_val.size() - 1], 16'h100F);

        // Start with busy never rising.
        rnd_rise = 1'b0;
        base = log_cyc.size();
        P = cyc;
        push(16'hF000);
        push(16'h2222);
        ticks(4);
        chk("t4_to_early", timeout_o, 0);
        tick();
        chk("t4_to_set", timeout_o, 1);
        ticks(5);
        chk("t4_npulse", log_cyc.size() - base, 2);
        chk("t4_next_val", log_val[base + 1], 16'h2222);
        chk("t4_next_cyc", log_cyc[base + 1], P + 8);
        rnd_rise = 1'b1;

        // Flush during a draw.
        rnd_hold = 30;
        push(16'hF000);
        wait_busy(1'b1, 20, "t5_busy_up");
        for (int i = 0; i < 5; i++) push(16'h3000 + 16'(i));
        chk("t5_level_pre", fifo_level_o, 5);
        chk("t5_ovf_pre", overflow_o, 1);
        chk("t5_to_pre", timeout_o, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t5_level", fifo_level_o, 0);
        chk("t5_ovf", overflow_o, 0);
        chk("t5_to", timeout_o, 0);
        base = log_cyc.size();
        wait_busy(1'b0, 40, "t5_busy_down");
        ticks(5);
        chk("t5_no_issue", log_cyc.size() - base, 0);
        chk("t5_lines", lines_done_o, exp_lines(4));
        chk("t5_idle", idle_o, 1);

        // Asynchronous reset mid-issue.
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        push(16'h0404);
        chk("t6_pre_valid", cmd_valid_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_rst_valid", cmd_valid_o, 0);
        chk("t6_rst_cmd", cmd_o, 0);
        chk("t6_rst_level", fifo_level_o, 0);
        chk("t6_rst_ready", host_cmd_ready_o, 1);
        chk("t6_rst_idle", idle_o, 1);
        chk("t6_rst_lines", lines_done_o, 0);
        base = log_cyc.size();
        ticks(3);
        reset_n_i = 1'b1;
        tick();
        chk("t6_no_issue", log_cyc.size() - base, 0);
        base = log_cyc.size();
        P = cyc;
        push(16'h0ABC);
        ticks(4);
        chk("t6_npulse", log_cyc.size() - base, 1);
        chk("t6_val", log_val[base], 16'h0ABC);
        chk("t6_cyc", log_cyc[base], P + 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
